// File: rtl/ifetch_pkg.sv
// Shared types and default geometry for the instruction fetch controller.
package ifetch_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        RD1  = 3'd2,
        RD2  = 3'd3,
        RD3  = 3'd4
    } state_e;

    localparam logic [14:0] DEF_BASE_ADDR = 15'h3000;
    localparam int unsigned DEF_MEM_BYTES = 32'd8192;

endpackage

// File: rtl/ifetch_word_asm.sv
// Big-endian word assembler: collects bytes 0..2 into a staging buffer and
// publishes the full word only when byte 3 arrives, so the output never shows a partial word.
module ifetch_word_asm
    import ifetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cap_en,
    input  logic        clr,
    input  logic [1:0]  byte_idx,
    input  logic [7:0]  byte_in,
    output logic [31:0] word
);

    logic [23:0] stage_q, stage_d;
    logic [31:0] word_q, word_d;

    // Staging buffer and atomic word publish.
    always_comb begin
        stage_d = stage_q;
        word_d  = word_q;
        if (clr) begin
            word_d = 32'd0;
        end else if (cap_en) begin
            case (byte_idx)
                2'd0:    stage_d[23:16] = byte_in;
                2'd1:    stage_d[15:8]  = byte_in;
                2'd2:    stage_d[7:0]   = byte_in;
                2'd3:    word_d         = {stage_q, byte_in};
                default: word_d         = word_q;
            endcase
        end else begin
            word_d = word_q;
        end
    end

    // Assembler state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= 24'd0;
            word_q  <= 32'd0;
        end else begin
            stage_q <= stage_d;
            word_q  <= word_d;
        end
    end

    assign word = word_q;

endmodule

// File: rtl/ifetch_ctrl.sv
// Byte-serial instruction fetch controller: four single-byte reads per word.
// Optional address range/alignment check is compiled in with IFETCH_RANGE_CHECK_EN.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter logic [14:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int unsigned MEM_BYTES = DEF_MEM_BYTES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [14:0] pc,
    output logic        ready,
    output logic [31:0] instr,
    output logic        valid,
    output logic        fault,
    output logic [12:0] mem_addr,
    input  logic [7:0]  mem_rdata
);

`ifdef IFETCH_RANGE_CHECK_EN
    localparam bit RANGE_CHECK_EN = 1'b1;
`else
    localparam bit RANGE_CHECK_EN = 1'b0;
`endif

    state_e      state_q, state_d;
    logic        ready_q, ready_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;
    logic [12:0] mem_addr_q, mem_addr_d;
    logic [12:0] start_off_s;
    logic [31:0] pc_w_s;
    logic [31:0] base_w_s;
    logic        range_bad_s;
    logic        cap_en_s;
    logic        clr_s;
    logic [1:0]  byte_idx_s;

    assign start_off_s = 13'(pc - BASE_ADDR);
    assign pc_w_s      = {17'd0, pc};
    assign base_w_s    = {17'd0, BASE_ADDR};

    // Rejection of misaligned or out-of-window fetch addresses.
    always_comb begin
        range_bad_s = 1'b0;
        if (RANGE_CHECK_EN) begin
            range_bad_s = (pc[1:0] != 2'b00) ||
                          (pc_w_s < base_w_s) ||
                          ((pc_w_s - base_w_s + 32'd3) >= MEM_BYTES);
        end else begin
            range_bad_s = 1'b0;
        end
    end

    // Next-state, byte address walk and assembler control.
    always_comb begin
        state_d    = state_q;
        valid_d    = 1'b0;
        fault_d    = 1'b0;
        mem_addr_d = 13'd0;
        cap_en_s   = 1'b0;
        clr_s      = 1'b0;
        byte_idx_s = 2'd0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (range_bad_s) begin
                        valid_d = 1'b1;
                        fault_d = 1'b1;
                        clr_s   = 1'b1;
                    end else begin
                        state_d    = RD0;
                        mem_addr_d = start_off_s;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD0: begin
                cap_en_s   = 1'b1;
                byte_idx_s = 2'd0;
                state_d    = RD1;
                mem_addr_d = mem_addr_q + 13'd1;
            end
            RD1: begin
                cap_en_s   = 1'b1;
                byte_idx_s = 2'd1;
                state_d    = RD2;
                mem_addr_d = mem_addr_q + 13'd1;
            end
            RD2: begin
                cap_en_s   = 1'b1;
                byte_idx_s = 2'd2;
                state_d    = RD3;
                mem_addr_d = mem_addr_q + 13'd1;
            end
            RD3: begin
                cap_en_s   = 1'b1;
                byte_idx_s = 2'd3;
                state_d    = IDLE;
                valid_d    = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ready_q    <= 1'b1;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            mem_addr_q <= 13'd0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    ifetch_word_asm u_word_asm (
        .clk      (clk),
        .rst      (rst),
        .cap_en   (cap_en_s),
        .clr      (clr_s),
        .byte_idx (byte_idx_s),
        .byte_in  (mem_rdata),
        .word     (instr)
    );

    assign ready    = ready_q;
    assign valid    = valid_q;
    assign fault    = fault_q;
    assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl with a scoreboard of expected valid pulses.
// Fault-path coverage is selected with IFETCH_RANGE_CHECK_EN.
module tb_ifetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [14:0] pc;
    logic        ready;
    logic [31:0] instr;
    logic        valid;
    logic        fault;
    logic [12:0] mem_addr;
    logic [7:0]  mem_rdata;

    logic [7:0] mem [0:8191];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] instr;
        logic        fault;
        int          due;
    } exp_t;
    exp_t sb[$];

    ifetch_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .pc        (pc),
        .ready     (ready),
        .instr     (instr),
        .valid     (valid),
        .fault     (fault),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every valid pulse must match the oldest expectation, on time.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_valid", 32'(valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("instr", instr, e.instr);
                    chk("fault", 32'(fault), 32'(e.fault));
                    chk("latency_cycle", 32'(cyc), 32'(e.due));
                end
            end else begin
                chk("fault_without_valid", 32'(fault), 32'd0);
                if (sb.size() > 0 && cyc > sb[0].due) begin
                    chk("missing_valid", 32'(valid), 32'd1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic start(input logic [14:0] a, input logic [31:0] ei, input logic ef);
        exp_t e;
        req     = 1'b1;
        pc      = a;
        e.instr = ei;
        e.fault = ef;
        e.due   = cyc + (ef ? 1 : 5);
        sb.push_back(e);
    endtask

    // Walks RD0..RD3 checking address, ready and held instr; ends in the valid cycle.
    task automatic rd_checks(input logic [12:0] off, input logic [31:0] hold,
                             input logic inject, input logic [14:0] junk_pc);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) req = 1'b0;
            chk("rd_mem_addr", 32'(mem_addr), 32'(off + 13'(k)));
            chk("rd_ready", 32'(ready), 32'd0);
            chk("rd_instr_hold", instr, hold);
            if (inject && k == 1) begin
                req = 1'b1;
                pc  = junk_pc;
            end
            if (k == 2) req = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom_range(255, 0));
        mem[0] = 8'h3C; mem[1] = 8'h08; mem[2] = 8'h00; mem[3] = 8'h10;
        mem[4] = 8'h20; mem[5] = 8'h09; mem[6] = 8'h00; mem[7] = 8'h05;
        mem[8188] = 8'hAA; mem[8189] = 8'hBB; mem[8190] = 8'hCC; mem[8191] = 8'hDD;

        rst = 1'b1;
        req = 1'b0;
        pc  = 15'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);

        // Single fetch, then back-to-back 0x3000 / 0x3004.
        @(negedge clk);
        start(15'h3000, 32'h3C080010, 1'b0);
        rd_checks(13'd0, 32'd0, 1'b0, 15'd0);
        start(15'h3000, 32'h3C080010, 1'b0);
        rd_checks(13'd0, 32'h3C080010, 1'b0, 15'd0);
        start(15'h3004, 32'h20090005, 1'b0);
        rd_checks(13'd4, 32'h3C080010, 1'b0, 15'd0);
        chk("idle_mem_addr", 32'(mem_addr), 32'd0);

        // A request during RD1 must be dropped.
        @(negedge clk);
        start(15'h3000, 32'h3C080010, 1'b0);
        rd_checks(13'd0, 32'h20090005, 1'b1, 15'h3008);
        repeat (3) begin
            @(negedge clk);
            chk("post_ignore_ready", 32'(ready), 32'd1);
        end

        // Reset during RD2 abandons the fetch.
        req = 1'b1;
        pc  = 15'h3004;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", 32'(ready), 32'd1);
        chk("midrst_instr", instr, 32'd0);
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
        repeat (6) @(negedge clk);

        start(15'h3004, 32'h20090005, 1'b0);
        rd_checks(13'd4, 32'd0, 1'b0, 15'd0);

`ifdef IFETCH_RANGE_CHECK_EN
        start(15'h4FFC, 32'hAABBCCDD, 1'b0);
        rd_checks(13'h1FFC, 32'h20090005, 1'b0, 15'd0);
        start(15'h2FFC, 32'd0, 1'b1);
        @(negedge clk);
        chk("fault_mem_addr", 32'(mem_addr), 32'd0);
        chk("fault_ready", 32'(ready), 32'd1);
        start(15'h3002, 32'd0, 1'b1);
        @(negedge clk);
        req = 1'b0;
        chk("fault2_ready", 32'(ready), 32'd1);
`else
        start(15'h5000, 32'h3C080010, 1'b0);
        rd_checks(13'd0, 32'h20090005, 1'b0, 15'd0);
`endif

        repeat (8) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
